// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding and shared width defaults for the hazard controller,
// decoder and pipeline registers.
package hazard_pkg;
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEF_REG_W = 5;
    localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: wrapping event counter with synchronous clear taking priority over increment.
module perf_counter
    import hazard_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_cnt <= '0;
        else
            r_cnt <= i_clr ? '0 : r_cnt + W'(i_inc);

    assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage pipeline (mem wait > branch > load-use)
// with a memory-wait watchdog and performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = DEF_REG_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_memread,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_busy,
    input  logic             i_cnt_clr,
    output logic             o_pc_stall,
    output logic             o_ifid_stall,
    output logic             o_ifid_flush,
    output logic             o_idex_stall,
    output logic             o_idex_flush,
    output logic             o_exmem_stall,
    output logic             o_memwb_flush,
    output logic             o_pc_redirect,
    output logic             o_mem_timeout,
    output logic             o_busy_state,
    output logic [CNT_W-1:0] o_cyc_cnt,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_wait_cnt, w_wait_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        w_lu, w_frz, w_br, w_ld;

    assign w_lu = i_ex_memread && (i_ex_rd != '0) &&
                  ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));

    // Gating with rst_n keeps every control at 0 while reset is held.
    assign w_frz = i_rst_n && i_mem_busy;
    assign w_br  = i_rst_n && !i_mem_busy && i_ex_br_taken;
    assign w_ld  = i_rst_n && !i_mem_busy && !i_ex_br_taken && w_lu;

    assign o_pc_stall    = w_frz || w_ld;
    assign o_ifid_stall  = w_frz || w_ld;
    assign o_ifid_flush  = w_br;
    assign o_idex_stall  = w_frz;
    assign o_idex_flush  = w_br || w_ld;
    assign o_exmem_stall = w_frz;
    assign o_memwb_flush = w_frz;
    assign o_pc_redirect = w_br;
    assign o_mem_timeout = r_timeout;
    assign o_busy_state  = (r_state == WAIT);

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= w_timeout_nxt;
        end

    // The watchdog fires on the edge where the freshly loaded wait count reaches TIMEOUT.
    always_comb begin
        w_state_nxt   = i_mem_busy ? WAIT : RUN;
        w_wait_nxt    = !i_mem_busy ? 16'd0 : (r_state == RUN) ? 16'd1 :
                        (r_wait_cnt < TO) ? r_wait_cnt + 16'd1 : r_wait_cnt;
        w_timeout_nxt = !i_cnt_clr && (r_timeout || (i_mem_busy && w_wait_nxt == TO));
    end

    perf_counter #(.W(CNT_W)) u_cyc (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(1'b1), .i_clr(i_cnt_clr), .o_cnt(o_cyc_cnt)
    );
    perf_counter #(.W(CNT_W)) u_stall (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(o_pc_stall), .i_clr(i_cnt_clr), .o_cnt(o_stall_cnt)
    );
    perf_counter #(.W(CNT_W)) u_flush (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(o_ifid_flush), .i_clr(i_cnt_clr), .o_cnt(o_flush_cnt)
    );
endmodule
